// File: rtl/uart_rx_oversampled_if.sv
// Host-side bundle of the oversampled UART receiver: serial input, parity mode
// and the received-byte/status outputs.
interface uart_rx_oversampled_if;
  logic       rx;
  logic [1:0] parity_type;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic [2:0] error_flag;

  modport master (
    output rx, parity_type,
    input  rx_data, rx_valid, rx_busy, error_flag
  );

  modport slave (
    input  rx, parity_type,
    output rx_data, rx_valid, rx_busy, error_flag
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8-bit UART receiver with 16x oversampling, 3-sample majority vote and
// optional odd/even parity check.
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | start bit; majority 1 at the decision point is a false start
//   DATA   | eight data bits, LSB first
//   PARITY | parity bit (only when odd/even parity is latched)
//   STOP   | stop bit; left as soon as the bit is decided
//   DONE   | one cycle: publish byte, flags and rx_valid
//   ABORT  | one cycle: publish false-start flag
module uart_rx_oversampled #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_rx_oversampled_if.slave bus
);

  localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, ABORT
  } state_t;

  state_t        state, nxt;
  logic          sync1, rxs, rxs_d;
  logic [TW-1:0] tdiv;
  logic [3:0]    s;
  logic [3:0]    bit_cnt;
  logic [1:0]    smp;
  logic [7:0]    shreg;
  logic [1:0]    par_lat;
  logic          par_acc;
  logic          stop_bit;
  logic          in_frame;
  logic          tick, decide, bit_end, fall, maj, par_en, par_err;

  assign fall    = rxs_d & ~rxs;
  assign tick    = in_frame && (tdiv == '0);
  assign decide  = tick && (s == 4'd9);
  assign bit_end = tick && (s == 4'd15);
  // the s=9 sample is the live line value, the other two were captured earlier
  assign maj     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign par_en  = par_lat[0] ^ par_lat[1];
  assign par_err = par_en && (par_acc != par_lat[0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (fall) nxt = START;
      START: begin
        if (decide && maj)  nxt = ABORT;
        else if (bit_end)   nxt = DATA;
      end
      DATA:    if (bit_end && bit_cnt == 4'd8) nxt = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) nxt = STOP;
      STOP:    if (decide) nxt = DONE;
      DONE:    nxt = IDLE;
      ABORT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_frame    = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);
    bus.rx_busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1          <= 1'b1;
      rxs            <= 1'b1;
      rxs_d          <= 1'b1;
      tdiv           <= '0;
      s              <= '0;
      bit_cnt        <= '0;
      smp            <= '0;
      shreg          <= '0;
      par_lat        <= '0;
      par_acc        <= 1'b0;
      stop_bit       <= 1'b0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.error_flag <= '0;
    end else begin
      sync1 <= bus.rx;
      rxs   <= sync1;
      rxs_d <= rxs;

      // parity mode tracks the input while idle and freezes on the start edge
      if (state == IDLE) begin
        tdiv    <= TICK_LAST;
        s       <= '0;
        bit_cnt <= '0;
        par_acc <= 1'b0;
        par_lat <= bus.parity_type;
      end else begin
        tdiv <= (tdiv == '0) ? TICK_LAST : tdiv - 1'b1;
        if (tick) begin
          s <= s + 1'b1;
          if (s == 4'd7) smp[0] <= rxs;
          if (s == 4'd8) smp[1] <= rxs;
          if (s == 4'd9) begin
            unique case (state)
              DATA: begin
                shreg   <= {maj, shreg[7:1]};
                par_acc <= par_acc ^ maj;
                bit_cnt <= bit_cnt + 1'b1;
              end
              PARITY:  par_acc  <= par_acc ^ maj;
              STOP:    stop_bit <= maj;
              default: ;
            endcase
          end
        end
      end

      bus.rx_valid <= (state == DONE);
      if (state == DONE) begin
        bus.rx_data    <= shreg;
        bus.error_flag <= {1'b0, par_err, ~stop_bit};
      end else if (state == ABORT) begin
        bus.error_flag <= 3'b100;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled at TICK_DIV=10 (160 clk per bit): frames are
// serialized onto rx and each expected delivery is queued for the monitor.
module tb_uart_rx_oversampled;

  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [7:0] last_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic [2:0] err;
    int         t;
  } exp_t;

  exp_t q[$];

  uart_rx_oversampled_if bus();

  uart_rx_oversampled #(
    .CLOCK_FREQ(1600),
    .BAUD_RATE (10),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Scoreboard monitor: every rx_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
        check("error_flag", {29'd0, bus.error_flag}, {29'd0, e.err});
        check("valid_cycle", cyc, e.t);
        check("busy_at_valid", {31'd0, bus.rx_busy}, 32'd0);
        last_data = e.data;
      end
    end
  end

  task automatic drive_bit(input logic v, input int blen, input bit noise);
    bus.rx = v;
    if (noise) begin
      // spike covers only the s=8 sample point of the bit
      repeat (85) @(negedge clk);
      bus.rx = ~v;
      repeat (10) @(negedge clk);
      bus.rx = v;
      repeat (blen - 95) @(negedge clk);
    end else begin
      repeat (blen) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] pt, input bit pflip,
                            input logic stop_val, input int blen, input bit noise,
                            input bit push, input bit scramble_pt);
    logic pe, pbit, perr;
    int   c0;
    exp_t e;
    pe   = (pt == 2'b01) || (pt == 2'b10);
    pbit = (^b) ^ (pt == 2'b01) ^ pflip;
    @(negedge clk);
    bus.parity_type = pt;
    bus.rx = 1'b0;
    c0 = cyc + 1;
    if (push) begin
      perr   = pe && (((^b) ^ pbit) != (pt == 2'b01));
      e.data = b;
      e.err  = {1'b0, perr, ~stop_val};
      e.t    = c0 + 2 + (pe ? 170 : 154) * 10 + 1;
      q.push_back(e);
    end
    repeat (blen) @(negedge clk);
    if (scramble_pt) bus.parity_type = 2'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(b[i], blen, noise);
    if (pe) drive_bit(pbit, blen, 1'b0);
    bus.rx = stop_val;
    repeat (blen) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, bus.rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    check({tag, "_rx_busy"}, {31'd0, bus.rx_busy}, 32'd0);
    check({tag, "_error_flag"}, {29'd0, bus.error_flag}, 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e_cyc;
    logic [7:0] b;
    bus.rx = 1'b1;
    bus.parity_type = 2'b00;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    gap(20);

    send_frame(8'h55, 2'b00, 1'b0, 1'b1, BIT, 1'b0, 1'b1, 1'b0);
    gap(30);

    send_frame(8'hA3, 2'b10, 1'b0, 1'b1, BIT, 1'b0, 1'b1, 1'b0);
    gap(30);
    send_frame(8'hA3, 2'b10, 1'b1, 1'b1, BIT, 1'b0, 1'b1, 1'b0);
    gap(30);
    send_frame(8'h5C, 2'b01, 1'b0, 1'b1, BIT, 1'b0, 1'b1, 1'b1);
    gap(30);

    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, BIT, 1'b0, 1'b1, 1'b0);
    gap(30);

    // 40-clk low glitch: false start, nothing delivered, data unchanged
    @(negedge clk);
    bus.rx = 1'b0;
    c0 = cyc + 1;
    e_cyc = c0 + 2;
    repeat (40) @(negedge clk);
    bus.rx = 1'b1;
    while (cyc < e_cyc + 100) @(negedge clk);
    check("false_start_busy_before", {31'd0, bus.rx_busy}, 32'd1);
    @(negedge clk);
    check("false_start_busy_after", {31'd0, bus.rx_busy}, 32'd0);
    check("false_start_error", {29'd0, bus.error_flag}, 32'b100);
    check("false_start_data_hold", {24'd0, bus.rx_data}, {24'd0, last_data});
    gap(200);

    send_frame(8'hF0, 2'b00, 1'b0, 1'b1, BIT, 1'b1, 1'b1, 1'b0);
    gap(30);

    // remote clock ~3% fast: 155-clk bits, frames back to back
    send_frame(8'h12, 2'b00, 1'b0, 1'b1, 155, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 2'b00, 1'b0, 1'b1, 155, 1'b0, 1'b1, 1'b0);
    gap(30);

    // break: all-zero frame, line stays low well past the frame
    send_frame(8'h00, 2'b00, 1'b0, 1'b0, BIT, 1'b0, 1'b1, 1'b0);
    bus.rx = 1'b0;
    gap(600);
    bus.rx = 1'b1;
    gap(30);

    // reset asserted in the middle of data bit 4, held until the frame ends
    fork
      send_frame(8'hC9, 2'b00, 1'b0, 1'b1, BIT, 1'b0, 1'b0, 1'b0);
      begin
        repeat (1 + 4 * BIT + 80) @(negedge clk);
        rst_n = 1'b0;
      end
    join
    gap(5);
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    gap(20);
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, BIT, 1'b0, 1'b1, 1'b0);
    gap(30);

    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      send_frame(b, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 BIT, 1'b0, 1'b1, 1'b1);
      gap($urandom_range(3, 40));
    end

    for (int i = 0; i < 4000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drain", q.size(), 32'd0);
    gap(20);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
